sseg_scan_drv: RTL

- IOBUS-mapped 4-digit seven-segment scan driver for the OTTER Basys3 top level.
- Sits downstream of the MCU I/O bus, alongside the LED port.
- Replaces the software-driven segs/anodes registers with a hardware display: firmware writes a 16-bit hex value and a control word once; the block multiplexes the digits autonomously.
- Pending registers are double-buffered into display (shadow) registers at frame boundaries, so partial updates never tear.

---
 rtl/sseg_pkg.sv | 26 ++
 rtl/sseg_hex_decode.sv | 13 +
 rtl/sseg_scan_drv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the seven-segment scan driver.
//   - default IOBUS addresses of the value and control registers
//   - control-word bit positions and reset value
//   - all-dark segment word and the active-low hex glyph table
package sseg_pkg;

   localparam logic [31:0] VALUE_ADDR_DEF = 32'h1100C004;
   localparam logic [31:0] CTRL_ADDR_DEF  = 32'h1100C008;

   // Control word: [3:0] dp mask, [4] leading-zero blank, [5] display enable
   localparam int unsigned CTRL_LZB = 4;
   localparam int unsigned CTRL_EN  = 5;
   localparam logic [5:0]  CTRL_RST = 6'b100000;

   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam logic [3:0]  AN_OFF    = 4'hF;

   // Active-low segment patterns, bit order g,f,e,d,c,b,a
   localparam logic [6:0] HEX_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational nibble to seven-segment glyph.
//   nib : 4-bit hex digit
//   pat : active-low segments g,f,e,d,c,b,a
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);

   assign pat = HEX_PAT[nib];

endmodule

// File: rtl/sseg_scan_drv.sv
// sseg_scan_drv: IOBUS-mapped 4-digit seven-segment scan driver.
//   clk        : system clock (s_clk)
//   rst_n      : asynchronous active-low reset
//   iobus_wr   : write strobe, single-cycle; a write is taken on any posedge
//                where iobus_wr=1 and iobus_addr matches a register address.
//                There is no back-pressure and no read-back.
//   iobus_addr : write address
//   iobus_out  : write data
//   segs       : cathodes, active-low, [7]=dp, [6:0]=g..a
//   an         : anodes, active-low, an[0]=rightmost digit
//
// Firmware writes land in pending registers. At the frame boundary (digit
// 3 -> 0) they are copied into shadow registers that drive the display, so
// a frame never mixes old and new contents.
module sseg_scan_drv
   import sseg_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 25000,
   parameter logic [31:0] VALUE_ADDR = VALUE_ADDR_DEF,
   parameter logic [31:0] CTRL_ADDR  = CTRL_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        iobus_wr,
   input  logic [31:0] iobus_addr,
   input  logic [31:0] iobus_out,
   output logic [7:0]  segs,
   output logic [3:0]  an
);

   localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

   logic [15:0] pend_val;
   logic [15:0] shadow_val;
   logic [5:0]  pend_ctrl;
   logic [5:0]  shadow_ctrl;
   logic [15:0] prescaler;
   logic [1:0]  digit;

   logic        tick;
   logic        frame_end;
   logic [1:0]  digit_nxt;
   logic [15:0] val_nxt;
   logic [5:0]  ctrl_nxt;
   logic [3:0]  nib;
   logic [6:0]  pat;
   logic        lead_zero;
   logic        blank;
   logic [3:0]  an_nxt;
   logic [7:0]  segs_nxt;

   logic        unused_data;
   assign unused_data = ^iobus_out[31:16];

   assign tick      = (prescaler == PRE_MAX);
   assign frame_end = tick && (digit == 2'd3);

   // ---------------------------------------------------------------
   // IOBUS write port into the pending registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val  <= '0;
         pend_ctrl <= CTRL_RST;
      end else if (iobus_wr) begin
         if (iobus_addr == VALUE_ADDR) pend_val  <= iobus_out[15:0];
         if (iobus_addr == CTRL_ADDR)  pend_ctrl <= iobus_out[5:0];
      end
   end

   // ---------------------------------------------------------------
   // Prescaler, digit sequencer and frame-boundary shadow copy.
   // The shadow copy samples the pending registers before any write on
   // the same edge lands, so a boundary-coincident write waits a frame.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler   <= '0;
         digit       <= '0;
         shadow_val  <= '0;
         shadow_ctrl <= CTRL_RST;
      end else begin
         if (tick) begin
            prescaler <= '0;
            digit     <= digit_nxt;
         end else begin
            prescaler <= prescaler + 16'd1;
         end
         if (frame_end) begin
            shadow_val  <= pend_val;
            shadow_ctrl <= pend_ctrl;
         end
      end
   end

   // ---------------------------------------------------------------
   // Next-slot output computation. Outputs are registered on the tick,
   // so they are built from the digit and shadow contents that will be
   // in effect after that edge (pending values on a frame boundary).
   // ---------------------------------------------------------------
   always_comb begin
      digit_nxt = digit + 2'd1;
      val_nxt   = frame_end ? pend_val  : shadow_val;
      ctrl_nxt  = frame_end ? pend_ctrl : shadow_ctrl;

      nib       = val_nxt[3:0];
      lead_zero = 1'b0;
      case (digit_nxt)
         2'd0: begin
            nib       = val_nxt[3:0];
            lead_zero = 1'b0;   // rightmost digit always shows, even "0"
         end
         2'd1: begin
            nib       = val_nxt[7:4];
            lead_zero = (val_nxt[15:4] == 12'd0);
         end
         2'd2: begin
            nib       = val_nxt[11:8];
            lead_zero = (val_nxt[15:8] == 8'd0);
         end
         2'd3: begin
            nib       = val_nxt[15:12];
            lead_zero = (val_nxt[15:12] == 4'd0);
         end
         default: begin
            nib       = val_nxt[3:0];
            lead_zero = 1'b0;
         end
      endcase

      // A lit dp on a digit keeps it visible through leading-zero blanking
      blank = !ctrl_nxt[CTRL_EN] ||
              (ctrl_nxt[CTRL_LZB] && lead_zero && !ctrl_nxt[digit_nxt]);

      if (blank) begin
         an_nxt   = AN_OFF;
         segs_nxt = SEG_BLANK;
      end else begin
         an_nxt   = ~(4'b0001 << digit_nxt);
         segs_nxt = {~ctrl_nxt[digit_nxt], pat};
      end
   end

   sseg_hex_decode u_hex (
      .nib (nib),
      .pat (pat)
   );

   // Output register: changes only on tick edges, dark out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an   <= AN_OFF;
         segs <= SEG_BLANK;
      end else if (tick) begin
         an   <= an_nxt;
         segs <= segs_nxt;
      end
   end

endmodule
